// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder.
// FSM states, access op type and word geometry.
package dmem_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic {
        OP_LD = 1'b0,
        OP_ST = 1'b1
    } op_e;

    localparam int WORD_BYTES  = 4;
    localparam int MAX_LATENCY = 15;

endpackage

// File: rtl/dmem_responder_if.sv
// LSU-side bus of the data-memory responder.
// align_err exists only when DMEM_ALIGN_CHECK_EN is defined.
interface dmem_responder_if;

    logic        read_mem;
    logic        write_mem;
    logic [31:0] addr;
    logic        addr_valid;
    logic [31:0] write_data;
    logic        write_data_valid;
    logic        mem_done;
    logic [31:0] DCache_data;
    logic        busy;
`ifdef DMEM_ALIGN_CHECK_EN
    logic        align_err;

    modport master (
        output read_mem, write_mem, addr, addr_valid,
        output write_data, write_data_valid,
        input  mem_done, DCache_data, busy, align_err
    );

    modport slave (
        input  read_mem, write_mem, addr, addr_valid,
        input  write_data, write_data_valid,
        output mem_done, DCache_data, busy, align_err
    );
`else
    modport master (
        output read_mem, write_mem, addr, addr_valid,
        output write_data, write_data_valid,
        input  mem_done, DCache_data, busy
    );

    modport slave (
        input  read_mem, write_mem, addr, addr_valid,
        input  write_data, write_data_valid,
        output mem_done, DCache_data, busy
    );
`endif

endinterface

// File: rtl/dmem_array.sv
// Single-port word RAM with registered read port.
// Contents are never reset; only the read register is.
module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IW          = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          re,
    input  logic [IW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we) mem_q[idx] <= wdata;
    end

    // Read register holds the last loaded word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata_q <= '0;
        else if (re) rdata_q <= mem_q[idx];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one word access at a time, fixed wait latency.
// Optional DMEM_ALIGN_CHECK_EN rejects misaligned accesses with align_err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);

    localparam int IW  = $clog2(DEPTH_WORDS);
    localparam int OFF = $clog2(WORD_BYTES);
    localparam logic [3:0] LAT =
        4'((LATENCY > MAX_LATENCY) ? MAX_LATENCY : LATENCY);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    op_e           op_q;
    logic [IW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic          st_req, ld_req, accept, perform, do_acc;
    logic          ram_we, ram_re;
    logic [31:0]   ram_rdata;
    logic          unused_addr;

    assign st_req = bus.write_mem & bus.addr_valid & bus.write_data_valid;
    assign ld_req = bus.read_mem & bus.addr_valid & ~bus.write_mem;
    assign accept = (state_q == IDLE) & (st_req | ld_req);
    assign perform = (state_q == WAIT) & (cnt_q == 4'd0);

    assign unused_addr = ^{bus.addr[31:OFF+IW], bus.addr[OFF-1:0]};

    // Next-state and wait-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WAIT;
                    cnt_d   = LAT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request at accept; later bus changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= OP_LD;
            idx_q   <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            op_q    <= st_req ? OP_ST : OP_LD;
            idx_q   <= bus.addr[OFF+:IW];
            wdata_q <= bus.write_data;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    logic mis_q;
    logic zero_q;

    // Remember whether the accepted address was misaligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         mis_q <= 1'b0;
        else if (accept) mis_q <= (bus.addr[OFF-1:0] != '0);
    end

    // Force load data to zero after a rejected access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else if (perform) begin
            if (mis_q)              zero_q <= 1'b1;
            else if (op_q == OP_LD) zero_q <= 1'b0;
        end
    end

    assign do_acc          = perform & ~mis_q;
    assign bus.DCache_data = zero_q ? 32'd0 : ram_rdata;
    assign bus.align_err   = (state_q == DONE) & mis_q;
`else
    assign do_acc          = perform;
    assign bus.DCache_data = ram_rdata;
`endif

    assign ram_we   = do_acc & (op_q == OP_ST);
    assign ram_re   = do_acc & (op_q == OP_LD);
    assign bus.mem_done = (state_q == DONE);
    assign bus.busy     = (state_q == WAIT);

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IW         (IW)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .we   (ram_we),
        .re   (ram_re),
        .idx  (idx_q),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

endmodule
